// File: rtl/task_inject_pkg.sv
// Shared types and helpers for the task injection arbiter.
package task_inject_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2,
    DRAIN   = 2'd3
  } fsm_t;

  // Payload word count carried in the low len_w bits of a frame header.
  function automatic logic [WORD_W-1:0] hdr_len(input logic [WORD_W-1:0] word, input int len_w);
    logic [WORD_W-1:0] mask;
    mask = (len_w >= WORD_W) ? '1 : ((WORD_W'(1) << len_w) - WORD_W'(1));
    return word & mask;
  endfunction

endpackage

// File: rtl/task_inject_arbiter_word_serializer.sv
// One-word hold register that emits a 32-bit word as WORD_W/FLIT_SIZE flits,
// low part first, holding the current flit while credit is withheld.
module word_serializer
  import task_inject_pkg::*;
#(
  parameter int FLIT_SIZE = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 i_load,
  input  logic [WORD_W-1:0]    i_word,
  input  logic                 i_credit,
  output logic                 o_empty,
  output logic                 o_last,
  output logic                 o_tx,
  output logic [FLIT_SIZE-1:0] o_data
);

  localparam int   NFLIT    = WORD_W / FLIT_SIZE;
  localparam logic LAST_IDX = 1'(NFLIT - 1);

  logic [WORD_W-1:0] r_word;
  logic              r_full;
  logic              r_idx;
  logic              w_xfer;
  logic [4:0]        w_shift;

  assign w_xfer  = r_full && i_credit;
  assign w_shift = r_idx ? 5'(FLIT_SIZE) : 5'd0;
  assign o_last  = (r_idx == LAST_IDX);
  assign o_empty = !r_full;
  assign o_tx    = r_full;
  assign o_data  = FLIT_SIZE'(r_word >> w_shift);

  // A load always wins: the top only loads when empty or on the last flit's transfer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_word <= '0;
      r_full <= 1'b0;
      r_idx  <= 1'b0;
    end else if (i_load) begin
      r_word <= i_word;
      r_full <= 1'b1;
      r_idx  <= 1'b0;
    end else if (w_xfer) begin
      if (o_last) begin
        r_full <= 1'b0;
        r_idx  <= 1'b0;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/task_inject_arbiter.sv
// Round-robin frame arbiter merging NUM_SRC word streams into one credit-flow flit stream.
// Optional per-source completed-frame counters: define TASK_INJECT_FRAME_CNT_EN.
module task_inject_arbiter
  import task_inject_pkg::*;
#(
  parameter  int NUM_SRC   = 2,
  parameter  int FLIT_SIZE = 32,
  parameter  int LEN_W     = 16,
  localparam int IDW       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NUM_SRC-1:0]              src_valid_i,
  input  logic [NUM_SRC-1:0][WORD_W-1:0]  src_data_i,
  output logic [NUM_SRC-1:0]              src_ready_o,
  input  logic [NUM_SRC-1:0]              src_eoa_i,
  output logic                            tx_o,
  input  logic                            credit_i,
  output logic [FLIT_SIZE-1:0]            data_o,
  output logic [IDW-1:0]                  src_id_o,
  output logic                            eoa_o
`ifdef TASK_INJECT_FRAME_CNT_EN
  ,
  output logic [NUM_SRC-1:0][15:0]        frame_cnt_o
`endif
);

  if (FLIT_SIZE != 16 && FLIT_SIZE != 32) begin : g_bad_flit
    $fatal(1, "task_inject_arbiter: FLIT_SIZE must be 16 or 32");
  end

  fsm_t              r_state, w_state_nx;
  logic [IDW-1:0]    r_ptr, r_grant, w_pick, w_ptr_nx;
  logic [LEN_W-1:0]  r_rem, w_rem_nx;
  logic              w_found, w_empty, w_last, w_busy, w_can_load, w_acc, w_drained;
  logic [WORD_W-1:0] w_word;

  assign w_busy     = (r_state == HDR) || (r_state == PAYLOAD);
  assign w_can_load = w_empty || (tx_o && credit_i && w_last);
  assign w_acc      = w_busy && w_can_load && src_valid_i[r_grant];
  assign w_word     = src_data_i[r_grant];
  assign w_drained  = (r_state == DRAIN) && w_empty;
  assign w_ptr_nx   = IDW'((int'(r_grant) + 1) % NUM_SRC);
  assign src_id_o   = r_grant;
  assign eoa_o      = (r_state == IDLE) && w_empty && (&src_eoa_i);

  // Descending scan so the source closest after the pointer wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_ptr;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (src_valid_i[(int'(r_ptr) + k) % NUM_SRC]) begin
        w_found = 1'b1;
        w_pick  = IDW'((int'(r_ptr) + k) % NUM_SRC);
      end else begin
        w_found = w_found;
      end
    end
  end

  always_comb begin
    src_ready_o = '0;
    if (w_busy && w_can_load) begin
      src_ready_o[r_grant] = 1'b1;
    end else begin
      src_ready_o = '0;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_rem_nx   = r_rem;
    case (r_state)
      IDLE: begin
        if (w_found) w_state_nx = HDR;
        else         w_state_nx = IDLE;
      end
      HDR: begin
        if (w_acc) begin
          w_rem_nx   = LEN_W'(hdr_len(w_word, LEN_W));
          w_state_nx = (w_rem_nx == '0) ? DRAIN : PAYLOAD;
        end else begin
          w_state_nx = HDR;
        end
      end
      PAYLOAD: begin
        if (w_acc && (r_rem != '0)) begin
          w_rem_nx   = r_rem - LEN_W'(1);
          w_state_nx = (r_rem == LEN_W'(1)) ? DRAIN : PAYLOAD;
        end else begin
          w_state_nx = PAYLOAD;
        end
      end
      DRAIN: begin
        if (w_empty) w_state_nx = IDLE;
        else         w_state_nx = DRAIN;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
      r_rem   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_rem   <= w_rem_nx;
      if (r_state == IDLE && w_found) r_grant <= w_pick;
      if (w_drained)                  r_ptr   <= w_ptr_nx;
    end
  end

`ifdef TASK_INJECT_FRAME_CNT_EN
  // Completed-frame counters tick on DRAIN->IDLE and wrap naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_cnt_o <= '0;
    end else if (w_drained) begin
      frame_cnt_o[r_grant] <= frame_cnt_o[r_grant] + 16'd1;
    end
  end
`endif

  word_serializer #(
    .FLIT_SIZE(FLIT_SIZE)
  ) u_ser (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .i_load   (w_acc),
    .i_word   (w_word),
    .i_credit (credit_i),
    .o_empty  (w_empty),
    .o_last   (w_last),
    .o_tx     (tx_o),
    .o_data   (data_o)
  );

endmodule

// File: tb/tb_task_inject_arbiter.sv
// Self-checking bench for task_inject_arbiter: vector table, hand corner cases,
// and randomized frames against a frame-level round-robin model.
module tb_task_inject_arbiter;

  localparam int NS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic [NS-1:0]        v, rdy, eoa_in, v16, rdy16;
  logic [NS-1:0][31:0]  d, d16;
  logic                 tx, tx16, credit, eoa, eoa16;
  logic [31:0]          dat;
  logic [15:0]          dat16;
  logic [0:0]           sid, sid16;
`ifdef TASK_INJECT_FRAME_CNT_EN
  logic [NS-1:0][15:0]  fcnt, fcnt16;
`endif

  task_inject_arbiter #(.NUM_SRC(NS), .FLIT_SIZE(32), .LEN_W(16)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .src_valid_i(v), .src_data_i(d), .src_ready_o(rdy),
    .src_eoa_i(eoa_in), .tx_o(tx), .credit_i(credit), .data_o(dat), .src_id_o(sid),
    .eoa_o(eoa)
`ifdef TASK_INJECT_FRAME_CNT_EN
    , .frame_cnt_o(fcnt)
`endif
  );

  task_inject_arbiter #(.NUM_SRC(NS), .FLIT_SIZE(16), .LEN_W(16)) u_dut16 (
    .clk_i(clk), .rst_ni(rst_n), .src_valid_i(v16), .src_data_i(d16), .src_ready_o(rdy16),
    .src_eoa_i(2'b00), .tx_o(tx16), .credit_i(credit), .data_o(dat16), .src_id_o(sid16),
    .eoa_o(eoa16)
`ifdef TASK_INJECT_FRAME_CNT_EN
    , .frame_cnt_o(fcnt16)
`endif
  );

  typedef struct {
    int          src;
    int          nw;
    logic [31:0] w [4];
    int          eid;
    int          enf;
  } vec_t;

  int total = 0, bad = 0, cyc = 0, first_acc = -1, mptr = 0;
  logic [NS-1:0] acc;
  logic          acc16;
  bit            cr_rand;
  logic          cr_force;
  logic [31:0]   q [NS][$];
  logic [31:0]   q16 [$];
  logic [31:0]   obs_d [$];
  int            obs_id [$];
  int            obs_cyc [$];
  logic [15:0]   obs16 [$];
  int            acc16_cyc [$];
  logic [31:0]   exp_d [$];
  int            exp_id [$];
  logic [31:0]   wq [NS][$];
  int            fl [NS][$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock: retire last cycle's accepts, drive inputs at negedge, sample before posedge.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < NS; i++) if (acc[i] && q[i].size() > 0) void'(q[i].pop_front());
    if (acc16 && q16.size() > 0) void'(q16.pop_front());
    for (int i = 0; i < NS; i++) begin
      v[i] = (q[i].size() > 0);
      d[i] = v[i] ? q[i][0] : 32'h0;
    end
    v16    = {1'b0, (q16.size() > 0)};
    d16    = {32'h0, (q16.size() > 0) ? q16[0] : 32'h0};
    credit = cr_rand ? ($urandom_range(3) != 0) : cr_force;
    #1;
    acc   = v & rdy;
    acc16 = v16[0] & rdy16[0];
    if (acc != '0 && first_acc < 0) first_acc = cyc;
    if (acc16) acc16_cyc.push_back(cyc);
    if (tx && credit) begin
      obs_d.push_back(dat);
      obs_id.push_back(int'(sid));
      obs_cyc.push_back(cyc);
    end
    if (tx16 && credit) obs16.push_back(dat16);
    cyc++;
  endtask

  task automatic clear_obs();
    obs_d.delete(); obs_id.delete(); obs_cyc.delete(); obs16.delete(); acc16_cyc.delete();
    first_acc = -1;
  endtask

  task automatic drain(input int budget);
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < budget) begin
      step();
      n++;
      if (q[0].size() == 0 && q[1].size() == 0 && q16.size() == 0 && !tx && !tx16) quiet++;
      else quiet = 0;
    end
    chk("drain_bound", 32'(quiet), 32'd3);
  endtask

  task automatic wait_obs(input int n, input int budget);
    int k = 0;
    while (obs_d.size() < n && k < budget) begin
      step();
      k++;
    end
    chk("wait_obs_bound", 32'(obs_d.size() >= n), 32'd1);
  endtask

  // Compare observed stream against exp_d/exp_id.
  task automatic cmp_stream(input string nm);
    chk({nm, "_count"}, 32'(obs_d.size()), 32'(exp_d.size()));
    for (int j = 0; j < exp_d.size() && j < obs_d.size(); j++) begin
      chk({nm, "_data"}, obs_d[j], exp_d[j]);
      chk({nm, "_id"}, 32'(obs_id[j]), 32'(exp_id[j]));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [4];
    logic [15:0] e16 [4];
    int          s, nf, len, n;
    bit          fnd;

    tbl[0] = '{0, 3, '{32'h0000_0002, 32'h0000_000A, 32'h0000_000B, 32'h0}, 0, 3};
    tbl[1] = '{1, 2, '{32'hABCD_0001, 32'h1234_5678, 32'h0, 32'h0}, 1, 2};
    tbl[2] = '{0, 1, '{32'hFFFF_0000, 32'h0, 32'h0, 32'h0}, 0, 1};
    tbl[3] = '{1, 4, '{32'h5A00_0003, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333}, 1, 4};
    e16    = '{16'h0001, 16'h0000, 16'hBEEF, 16'hDEAD};

    rst_n = 1'b0; v = '0; d = '0; v16 = '0; d16 = '0; eoa_in = '0; credit = 1'b0;
    acc = '0; acc16 = 1'b0; cr_rand = 1'b0; cr_force = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_tx", 32'(tx), 32'd0);
    chk("reset_data", dat, 32'h0);
    chk("reset_ready", 32'(rdy), 32'd0);
    chk("reset_sid", 32'(sid), 32'd0);
    chk("reset_eoa", 32'(eoa), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Header-only frames from both sources alternate 0,1,0,1...
    clear_obs(); exp_d.delete(); exp_id.delete();
    for (int k = 0; k < 4; k++) begin
      q[0].push_back(32'h0000_0000);
      q[1].push_back(32'hC0DE_0000);
    end
    for (int j = 0; j < 8; j++) begin
      exp_d.push_back((j % 2 == 1) ? 32'hC0DE_0000 : 32'h0000_0000);
      exp_id.push_back(j % 2);
    end
    drain(120);
    cmp_stream("rr_hdr_only");

    // A src1 frame arriving mid-src0-frame is not interleaved.
    clear_obs(); exp_d.delete(); exp_id.delete();
    q[0] = {32'h0000_0003, 32'hA0, 32'hA1, 32'hA2};
    repeat (3) step();
    q[1] = {32'h0000_0001, 32'hB0};
    exp_d  = {32'h3, 32'hA0, 32'hA1, 32'hA2, 32'h1, 32'hB0};
    exp_id = {0, 0, 0, 0, 1, 1};
    drain(60);
    cmp_stream("no_interleave");

    // Randomized frames with random credit against a frame-level round-robin model.
    mptr = 0;
    for (int r = 0; r < 3; r++) begin
      clear_obs(); exp_d.delete(); exp_id.delete();
      for (int si = 0; si < NS; si++) begin
        nf = $urandom_range(1, 3);
        for (int f = 0; f < nf; f++) begin
          len = $urandom_range(0, 3);
          wq[si].push_back(($urandom() & 32'hFFFF_0000) | 32'(len));
          for (int j = 0; j < len; j++) wq[si].push_back($urandom());
          fl[si].push_back(len + 1);
        end
        q[si] = wq[si];
      end
      while (fl[0].size() + fl[1].size() > 0) begin
        fnd = 1'b0; s = 0;
        for (int k = 0; k < NS; k++) begin
          if (!fnd && fl[(mptr + k) % NS].size() > 0) begin
            fnd = 1'b1;
            s = (mptr + k) % NS;
          end
        end
        n = fl[s].pop_front();
        for (int j = 0; j < n; j++) begin
          exp_d.push_back(wq[s].pop_front());
          exp_id.push_back(s);
        end
        mptr = (s + 1) % NS;
      end
      cr_rand = 1'b1;
      drain(600);
      cr_rand = 1'b0;
      cmp_stream("random");
    end

    // Table of single-source frames; flits must follow each accept by one cycle.
    for (int t = 0; t < 4; t++) begin
      clear_obs();
      for (int j = 0; j < tbl[t].nw; j++) q[tbl[t].src].push_back(tbl[t].w[j]);
      drain(60);
      chk("vec_count", 32'(obs_d.size()), 32'(tbl[t].enf));
      for (int j = 0; j < tbl[t].enf && j < obs_d.size(); j++) begin
        chk("vec_data", obs_d[j], tbl[t].w[j]);
        chk("vec_id", 32'(obs_id[j]), 32'(tbl[t].eid));
        chk("vec_latency", 32'(obs_cyc[j]), 32'(first_acc + 1 + j));
      end
    end

    // 16-bit flits: low half first, ready every other cycle.
    clear_obs();
    q16 = {32'h0000_0001, 32'hDEAD_BEEF};
    drain(60);
    chk("f16_count", 32'(obs16.size()), 32'd4);
    for (int j = 0; j < 4 && j < obs16.size(); j++) chk("f16_data", 32'(obs16[j]), 32'(e16[j]));
    chk("f16_accepts", 32'(acc16_cyc.size()), 32'd2);
    if (acc16_cyc.size() == 2) chk("f16_ready_spacing", 32'(acc16_cyc[1] - acc16_cyc[0]), 32'd2);

    // Credit withheld for 5 cycles mid-payload.
    clear_obs(); exp_d.delete(); exp_id.delete();
    q[0] = {32'h0000_0004, 32'h1, 32'h2, 32'h3, 32'h4};
    wait_obs(2, 50);
    cr_force = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_tx", 32'(tx), 32'd1);
      chk("stall_data", dat, 32'h2);
      chk("stall_no_accept", 32'(acc), 32'd0);
    end
    cr_force = 1'b1;
    drain(60);
    exp_d  = {32'h4, 32'h1, 32'h2, 32'h3, 32'h4};
    exp_id = {0, 0, 0, 0, 0};
    cmp_stream("stall");

    // End-of-applications waits for the in-flight src1 frame to drain.
    clear_obs(); exp_d.delete(); exp_id.delete();
    q[1] = {32'h0000_0002, 32'h77, 32'h88};
    wait_obs(1, 50);
    eoa_in = 2'b11;
    n = 0;
    while (tx && n < 50) begin
      chk("eoa_while_busy", 32'(eoa), 32'd0);
      step();
      n++;
    end
    n = 0;
    while (!eoa && n < 4) begin
      step();
      n++;
    end
    chk("eoa_done", 32'(eoa), 32'd1);
    exp_d  = {32'h2, 32'h77, 32'h88};
    exp_id = {1, 1, 1};
    cmp_stream("eoa_frame");
    eoa_in = 2'b00;

    // Asynchronous reset mid-payload, then a fresh frame.
    clear_obs();
    q[1] = {32'h0000_0003, 32'h5, 32'h6, 32'h7};
    wait_obs(2, 50);
    chk("pre_reset_sid", 32'(sid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_reset_tx", 32'(tx), 32'd0);
    chk("mid_reset_data", dat, 32'h0);
    chk("mid_reset_ready", 32'(rdy), 32'd0);
    chk("mid_reset_sid", 32'(sid), 32'd0);
    chk("mid_reset_eoa", 32'(eoa), 32'd0);
`ifdef TASK_INJECT_FRAME_CNT_EN
    chk("mid_reset_fcnt", 32'(fcnt), 32'd0);
`endif
    q[0].delete(); q[1].delete(); acc = '0; acc16 = 1'b0;
    clear_obs();
    step(); step();
    @(negedge clk);
    rst_n = 1'b1;
    exp_d.delete(); exp_id.delete();
    q[0] = {32'h0000_0001, 32'h55};
    exp_d  = {32'h1, 32'h55};
    exp_id = {0, 0};
    drain(60);
    cmp_stream("post_reset");
`ifdef TASK_INJECT_FRAME_CNT_EN
    chk("post_reset_fcnt0", 32'(fcnt[0]), 32'd1);
    chk("post_reset_fcnt1", 32'(fcnt[1]), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/task_inject_arbiter.md
Name: task_inject_arbiter

Overview:
- Synthesisable, parametrised successor to the file-driven task injector.
- Merges NUM_SRC injection-frame word streams (app descriptors, task binaries) into one credit-flow-controlled flit stream toward the NoC injection port.
- Arbitrates round-robin at frame boundaries and serialises 32-bit words into FLIT_SIZE-bit flits.
- Raises end-of-applications once every source has finished.

Parameters:
- NUM_SRC, 2: number of input word streams; 1..8.
- FLIT_SIZE, 32: output flit width; 16 or 32 only. Any other value is a $fatal at elaboration.
- LEN_W, 16: width of the payload-length field in a frame header word.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- src_valid_i  in  NUM_SRC  per-source word valid.
- src_data_i  in  NUM_SRC x 32  per-source word.
- src_ready_o  out  NUM_SRC  per-source word accept.
- src_eoa_i  in  NUM_SRC  source has no further frames; level signal.
- tx_o  out  1  flit valid toward NoC.
- credit_i  in  1  NoC can accept. A flit transfers when tx_o && credit_i.
- data_o  out  FLIT_SIZE  flit.
- src_id_o  out  $clog2(NUM_SRC) or 1  source owning the current frame.
- eoa_o  out  1  all sources done and block drained.

Behaviour:
- Frame format:
  - Word 0 is the header; L = header[LEN_W-1:0] is the payload word count, followed by L payload words.
  - The header itself is forwarded. L=0 gives a header-only frame.
  - Header bits above LEN_W are forwarded untouched.
- Handshake: a word is accepted on src_valid_i[i] && src_ready_o[i]. src_ready_o is nonzero only for the granted source.
- Hold register: one 32-bit word plus flit index.
  - ready = granted && (reg empty || (tx_o && credit_i && last flit of reg)).
  - This gives back-to-back words at 1 word/cycle for FLIT_SIZE=32 with continuous credit, and 1 word per 2 cycles for FLIT_SIZE=16.
- Latency: word accepted at cycle N → first flit on data_o with tx_o=1 at N+1.
- Serialisation:
  - FLIT_SIZE=16: low half first, then high half.
  - data_o is held stable while tx_o && !credit_i.
- FSM:
  - IDLE: pointer-based round-robin over src_valid_i. Grant is registered; then go to HDR. With no valid source, stay in IDLE.
  - HDR: accept header and load remaining = L. If L=0, go to DRAIN; otherwise go to PAYLOAD.
  - PAYLOAD: each accepted word decrements remaining; accepting the last word goes to DRAIN.
  - DRAIN: wait until the hold register empties, then go to IDLE. The pointer advances to granted+1 mod NUM_SRC.
- Round-robin:
  - After reset the pointer is 0, so source 0 has highest priority.
  - A granted source stays locked until its frame fully drains. Other sources' valids are ignored meanwhile.
- src_id_o: registered at grant; holds its value in IDLE.
- eoa_o = (state==IDLE) && reg empty && &src_eoa_i. A source asserting eoa while still valid is still served; eoa_o waits.
- Reset mid-frame: all state is discarded; no partial-frame recovery.
- Reset values: tx_o=0, data_o=0, src_ready_o=0, src_id_o=0, eoa_o=0, state=IDLE, pointer=0, remaining=0.
- remaining counter: LEN_W bits. It never underflows because decrements happen only while remaining>0.

Optional Feature:
- Macro TASK_INJECT_FRAME_CNT_EN.
- When defined:
  - Adds output frame_cnt_o [NUM_SRC x 16]: per-source count of completed frames, incremented on the DRAIN→IDLE transition.
  - The counter wraps 0xFFFF→0 and resets to 0.
- When undefined: neither the port nor the counters exist, and behaviour is otherwise identical.

Decomposition:
- Package task_inject_pkg holds:
  - fsm_t enum {IDLE, HDR, PAYLOAD, DRAIN};
  - the WORD_W=32 constant;
  - the header field function hdr_len(word, LEN_W).
- One sub-module, word_serializer: hold register plus flit index, parametrised by FLIT_SIZE.
  - Interface: load/word in, empty/last, tx/credit/data out.

Test Plan:
- NUM_SRC=2, FLIT_SIZE=32, src0 frame {0x2, 0xA, 0xB}, credit_i=1 → data_o 0x2, 0xA, 0xB on 3 consecutive cycles starting 1 cycle after the first accept; src_id_o=0.
- FLIT_SIZE=16, frame {0x1, 0xDEADBEEF} → flits 0x0001, 0x0000, 0xBEEF, 0xDEAD; src_ready_o high every other cycle.
- Both sources valid with header-only frames (L=0), repeated 4x → grants alternate 0,1,0,1. A src1 frame started mid-src0-frame is not interleaved.
- credit_i low for 5 cycles mid-payload → data_o stable and tx_o=1 throughout, no word accepted, stream resumes with no loss or duplication.
- Both src_eoa_i=1 while src1 frame in flight → eoa_o=0 until the last flit transfers, then eoa_o=1 in IDLE.
- rst_ni low mid-payload → all outputs return to reset values asynchronously. After release, a fresh frame from src0 is forwarded correctly (with TASK_INJECT_FRAME_CNT_EN, frame_cnt_o resets to 0).
